// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue between the host register interface and the SD data master.
// Host writes two-word descriptors; the master pulls them with a request/ack handshake and frees slots via a_cmp.
`timescale 1ns/1ps
module sd_bd_queue #(
    parameter int BD_NUM     = 16,
    parameter int BD_WIDTH   = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_m,
    input  logic [DATA_WIDTH-1:0] dat_in_m,
    input  logic                  bd_clr,
    output logic                  new_bd,
    output logic [BD_WIDTH-1:0]   free_bd,
    input  logic                  re_s,
    output logic                  ack_o_s,
    output logic [DATA_WIDTH-1:0] dat_out_s,
    input  logic                  a_cmp,
    output logic                  bd_ovf
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WORD0 = 3'd1,
        ST_GAP   = 3'd2,
        ST_WORD1 = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [BD_WIDTH-1:0] FULL_CNT = BD_WIDTH'(BD_NUM);
    localparam logic [BD_WIDTH-1:0] ONE      = BD_WIDTH'(1);
    localparam logic [BD_WIDTH-1:0] ZERO     = BD_WIDTH'(0);

    // Pointers index words, so one extra bit over the slot count covers 2*BD_NUM entries.
    logic [DATA_WIDTH-1:0] mem_q [2*BD_NUM];

    state_t                state_q, state_d;
    logic [BD_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [BD_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [BD_WIDTH-1:0]   free_q, free_d;
    logic [BD_WIDTH-1:0]   pend_q, pend_d;
    logic                  new_bd_q, new_bd_d;
    logic                  ack_q, ack_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  wr_en_s;
    logic                  commit_s;
    logic                  rd_done_s;
    logic                  cmp_s;

    // Next-state logic for the write side, read FSM and slot accounting
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        free_d    = free_q;
        pend_d    = pend_q;
        new_bd_d  = 1'b0;
        ack_d     = 1'b0;
        ovf_d     = 1'b0;
        dat_d     = dat_q;
        wr_en_s   = 1'b0;
        commit_s  = 1'b0;
        rd_done_s = 1'b0;
        cmp_s     = 1'b0;
        if (bd_clr) begin
            state_d  = ST_IDLE;
            wr_ptr_d = ZERO;
            rd_ptr_d = ZERO;
            free_d   = FULL_CNT;
            pend_d   = ZERO;
            dat_d    = DATA_WIDTH'(0);
        end else begin
            if (we_m) begin
                if (free_q != ZERO) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE;
                    commit_s = wr_ptr_q[0];
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                wr_en_s = 1'b0;
            end

            // Ack and data are launched on the transition into an ack state so they stay registered
            case (state_q)
                ST_IDLE: begin
                    if (re_s && (pend_q != ZERO)) begin
                        state_d  = ST_WORD0;
                        ack_d    = 1'b1;
                        dat_d    = mem_q[rd_ptr_q];
                        rd_ptr_d = rd_ptr_q + ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WORD0: state_d = ST_GAP;
                ST_GAP: begin
                    if (re_s) begin
                        state_d   = ST_WORD1;
                        ack_d     = 1'b1;
                        dat_d     = mem_q[rd_ptr_q];
                        rd_ptr_d  = rd_ptr_q + ONE;
                        rd_done_s = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                ST_WORD1: state_d = ST_HOLD;
                ST_HOLD: begin
                    if (!re_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            cmp_s    = a_cmp && (free_q != FULL_CNT);
            new_bd_d = commit_s;
            if (commit_s && !cmp_s) begin
                free_d = free_q - ONE;
            end else if (!commit_s && cmp_s) begin
                free_d = free_q + ONE;
            end else begin
                free_d = free_q;
            end
            if (commit_s && !rd_done_s) begin
                pend_d = pend_q + ONE;
            end else if (!commit_s && rd_done_s) begin
                pend_d = pend_q - ONE;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= ZERO;
            rd_ptr_q <= ZERO;
            free_q   <= FULL_CNT;
            pend_q   <= ZERO;
            new_bd_q <= 1'b0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            dat_q    <= DATA_WIDTH'(0);
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            free_q   <= free_d;
            pend_q   <= pend_d;
            new_bd_q <= new_bd_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
            dat_q    <= dat_d;
        end
    end

    // Descriptor storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= dat_in_m;
        end
    end

    assign new_bd    = new_bd_q;
    assign free_bd   = free_q;
    assign ack_o_s   = ack_q;
    assign dat_out_s = dat_q;
    assign bd_ovf    = ovf_q;
endmodule

// File: tb/tb_sd_bd_queue.sv
// Bench for sd_bd_queue: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model of slots, pending descriptors and ack timing rules.
`timescale 1ns/1ps
module tb_sd_bd_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_m = 1'b0;
    logic [31:0] dat_in_m = 32'd0;
    logic        bd_clr = 1'b0;
    logic        new_bd;
    logic [4:0]  free_bd;
    logic        re_s = 1'b0;
    logic        ack_o_s;
    logic [31:0] dat_out_s;
    logic        a_cmp = 1'b0;
    logic        bd_ovf;

    int checks = 0;
    int errors = 0;

    sd_bd_queue #(.BD_NUM(16), .BD_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .we_m(we_m), .dat_in_m(dat_in_m), .bd_clr(bd_clr),
        .new_bd(new_bd), .free_bd(free_bd), .re_s(re_s), .ack_o_s(ack_o_s),
        .dat_out_s(dat_out_s), .a_cmp(a_cmp), .bd_ovf(bd_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word queue, slot counts and ack spacing rules
    logic [31:0] wq[$];
    logic [31:0] half_w = 32'd0;
    int  m_free = 16, m_pend = 0, m_unfreed = 0, ecount = 0, a0 = 0, a1 = 0;
    bit  m_wpar = 1'b0, m_mid = 1'b0, m_blocked = 1'b0;
    bit  e_new = 1'b0, e_ack = 1'b0, e_ovf = 1'b0;
    logic [31:0] e_dat = 32'd0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst || bd_clr) begin
            wq.delete();
            m_free = 16; m_pend = 0; m_unfreed = 0; m_wpar = 1'b0;
            m_mid = 1'b0; m_blocked = 1'b0;
            e_new = 1'b0; e_ack = 1'b0; e_ovf = 1'b0; e_dat = 32'd0;
        end else begin
            bit commit, cmp, rdone;
            ecount++;
            commit = 1'b0; cmp = 1'b0; rdone = 1'b0;
            e_new = 1'b0; e_ovf = 1'b0; e_ack = 1'b0;
            if (we_m) begin
                if (m_free != 0) begin
                    if (m_wpar) commit = 1'b1;
                    else half_w = dat_in_m;
                    m_wpar = ~m_wpar;
                end else begin
                    e_ovf = 1'b1;
                end
            end
            if (a_cmp && m_free != 16) cmp = 1'b1;
            if (a_cmp && m_unfreed > 0) m_unfreed--;
            if (m_mid) begin
                if (ecount >= a0 + 2 && re_s) begin
                    e_ack = 1'b1; e_dat = wq.pop_front();
                    m_mid = 1'b0; m_blocked = 1'b1; a1 = ecount; rdone = 1'b1;
                    m_unfreed++;
                end
            end else if (m_blocked) begin
                if (ecount >= a1 + 2 && !re_s) m_blocked = 1'b0;
            end else if (re_s && m_pend != 0) begin
                e_ack = 1'b1; e_dat = wq.pop_front(); m_mid = 1'b1; a0 = ecount;
            end
            if (commit) begin
                wq.push_back(half_w);
                wq.push_back(dat_in_m);
            end
            e_new  = commit;
            m_free = m_free - int'(commit) + int'(cmp);
            m_pend = m_pend + int'(commit) - int'(rdone);
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("new_bd", {31'd0, new_bd}, {31'd0, e_new});
            chk("ack_o_s", {31'd0, ack_o_s}, {31'd0, e_ack});
            chk("bd_ovf", {31'd0, bd_ovf}, {31'd0, e_ovf});
            chk("free_bd", {27'd0, free_bd}, 32'(m_free));
            chk("dat_out_s", dat_out_s, e_dat);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] w);
        we_m = 1'b1; dat_in_m = w;
        tick();
        we_m = 1'b0;
    endtask

    task automatic read_desc(input bit do_cmp);
        int n;
        n = 0;
        re_s = 1'b1;
        for (int i = 0; i < 12 && n < 2; i++) begin
            tick();
            if (ack_o_s) n++;
        end
        chk("read_acks", 32'(n), 32'd2);
        re_s = 1'b0;
        tick(); tick();
        if (do_cmp) begin
            a_cmp = 1'b1; tick(); a_cmp = 1'b0;
        end
    endtask

    task automatic clr();
        bd_clr = 1'b1; tick(); bd_clr = 1'b0;
    endtask

    initial begin
        int nack, first_i, second_i;
        logic [31:0] d0, d1;
        tick(); tick();
        chk("rst_free", {27'd0, free_bd}, 32'd16);
        chk("rst_ack", {31'd0, ack_o_s}, 32'd0);
        chk("rst_new", {31'd0, new_bd}, 32'd0);
        #2 rst = 1'b0;

        // Empty queue never acks
        re_s = 1'b1; nack = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (ack_o_s) nack++; end
        re_s = 1'b0;
        chk("empty_acks", 32'(nack), 32'd0);
        tick(); tick();

        // Single descriptor
        wr(32'h0000_1000);
        wr(32'h0000_0200);
        chk("single_new", {31'd0, new_bd}, 32'd1);
        chk("single_free", {27'd0, free_bd}, 32'd15);
        re_s = 1'b1; nack = 0; first_i = 0; second_i = 0; d0 = 32'd0; d1 = 32'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_o_s) begin
                if (nack == 0) begin first_i = i; d0 = dat_out_s; end
                else begin second_i = i; d1 = dat_out_s; end
                nack++;
            end
        end
        chk("single_acks", 32'(nack), 32'd2);
        chk("single_first_lat", 32'(first_i), 32'd0);
        chk("single_gap", 32'(second_i - first_i), 32'd2);
        chk("single_d0", d0, 32'h0000_1000);
        chk("single_d1", d1, 32'h0000_0200);
        re_s = 1'b0; tick(); tick();
        a_cmp = 1'b1; tick(); a_cmp = 1'b0;
        chk("single_cmp_free", {27'd0, free_bd}, 32'd16);

        // Full queue, overflow, drain, and a second fill to wrap pointers
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 32; i++) wr($urandom);
            chk("full_free", {27'd0, free_bd}, 32'd0);
            wr(32'hDEAD_BEEF);
            chk("ovf_pulse", {31'd0, bd_ovf}, 32'd1);
            chk("ovf_free", {27'd0, free_bd}, 32'd0);
            for (int i = 0; i < 16; i++) read_desc(1'b1);
            chk("drain_free", {27'd0, free_bd}, 32'd16);
        end

        // Commit and a_cmp in the same cycle
        for (int i = 0; i < 12; i++) wr($urandom);
        read_desc(1'b0);
        chk("pre_sim_free", {27'd0, free_bd}, 32'd10);
        wr(32'h1111_0000);
        we_m = 1'b1; dat_in_m = 32'h1111_0001; a_cmp = 1'b1;
        tick();
        we_m = 1'b0; a_cmp = 1'b0;
        chk("sim_cmp_free", {27'd0, free_bd}, 32'd10);
        clr();
        chk("clr_free", {27'd0, free_bd}, 32'd16);

        // Commit in the same cycle as the second read word
        wr(32'h2222_0000); wr(32'h2222_0001);
        re_s = 1'b1; tick();
        wr(32'h3333_0000);
        wr(32'h3333_0001);
        re_s = 1'b0; tick(); tick(); tick();
        read_desc(1'b0);
        chk("word1_commit_dat", dat_out_s, 32'h3333_0001);

        // Spurious completion on an empty queue
        clr();
        a_cmp = 1'b1; tick(); a_cmp = 1'b0;
        chk("spurious_free", {27'd0, free_bd}, 32'd16);

        // Abort during GAP, by bd_clr then by rst
        for (int k = 0; k < 2; k++) begin
            wr(32'h4444_0000); wr(32'h4444_0001); wr(32'h5555_0000);
            re_s = 1'b1; tick(); re_s = 1'b0; tick();
            if (k == 0) begin
                clr();
            end else begin
                #2 rst = 1'b1; tick(); #2 rst = 1'b0;
            end
            chk("abort_ack", {31'd0, ack_o_s}, 32'd0);
            chk("abort_free", {27'd0, free_bd}, 32'd16);
            wr(32'hA5A5_0001); wr(32'hA5A5_0002);
            read_desc(1'b1);
            chk("abort_dat", dat_out_s, 32'hA5A5_0002);
        end

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            we_m     = ($urandom % 3) == 0;
            dat_in_m = $urandom;
            re_s     = ($urandom % 4) != 0;
            a_cmp    = (m_unfreed > 0) && (($urandom % 3) == 0);
            bd_clr   = ($urandom % 500) == 0;
            tick();
        end
        we_m = 1'b0; re_s = 1'b0; a_cmp = 1'b0; bd_clr = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sd_bd_queue.md
# sd_bd_queue

Buffer-descriptor queue sitting directly upstream of the SD data master, one instance per direction (TX and RX). Software writes descriptors as pairs of 32-bit words (system address, then card block address) through the host register interface. The data master pulls them word by word with a level request / pulse acknowledge handshake. A slot is returned to the free pool only when the master signals completion of that descriptor's transfer.

## Interface
Parameters:
- BD_NUM, 16, descriptor slots; power of two, ≥2.
- BD_WIDTH, 5, width of the free count; equals log2(BD_NUM)+1.
- DATA_WIDTH, 32, word width; one descriptor is two words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- we_m  in  1  host write strobe; one word per cycle with we_m=1.
- dat_in_m  in  DATA_WIDTH  host write data; word 0 is sys_adr, word 1 is cmd_arg.
- bd_clr  in  1  synchronous clear of the queue (software abort).
- new_bd  out  1  one-cycle pulse when a complete descriptor is committed.
- free_bd  out  BD_WIDTH  free slots; equals BD_NUM when the queue is empty.
- re_s  in  1  master read request (level).
- ack_o_s  out  1  one-cycle pulse; dat_out_s valid in that cycle.
- dat_out_s  out  DATA_WIDTH  descriptor word to master.
- a_cmp  in  1  one-cycle pulse from master: oldest outstanding descriptor done, free its slot.
- bd_ovf  out  1  one-cycle pulse: host write dropped, queue full.

## Operation
- Storage: 2*BD_NUM words. Pointers: wr_ptr (word index, wraps 2*BD_NUM-1→0) and rd_ptr (word index, wraps the same way). Counters: free_bd (0..BD_NUM) and pend (committed-but-unread descriptors, 0..BD_NUM).
- Host write:
  - we_m=1 with free_bd≠0 stores dat_in_m at wr_ptr and increments wr_ptr.
  - If wr_ptr[0] was 1 (second word), the descriptor commits: new_bd=1 next cycle, free_bd−1, pend+1.
  - we_m=1 with free_bd=0 drops the word: wr_ptr unchanged, bd_ovf pulses.
- Master read FSM states: IDLE, WORD0, GAP, WORD1, HOLD.
  - IDLE → WORD0 when re_s=1 and pend≠0.
  - WORD0: ack_o_s=1, dat_out_s=mem[rd_ptr], rd_ptr+1; → GAP.
  - GAP: ack_o_s=0; → WORD1 if re_s=1, else stay.
  - WORD1: ack_o_s=1, second word, rd_ptr+1, pend−1; → HOLD.
  - HOLD: → IDLE when re_s=0. Prevents overread while the master is still dropping re_s.
- Completion: a_cmp=1 increments free_bd. a_cmp with free_bd=BD_NUM is ignored (no wrap).
- Simultaneous events in one cycle:
  - commit + a_cmp: free_bd unchanged.
  - commit + WORD1: pend unchanged.
  - Host write and master read may target different slots in the same cycle; a slot is never read before it is committed, and never rewritten before its a_cmp.
- bd_clr: pointers, pend and FSM go to reset state, free_bd=BD_NUM, outputs low. bd_clr overrides all simultaneous inputs.
- rst mid-operation: same as bd_clr, asynchronous. A partially written descriptor (one word) is discarded.

## Timing
- Reset values: new_bd=0, ack_o_s=0, dat_out_s=0, bd_ovf=0, free_bd=BD_NUM, internal pointers/pend=0, FSM=IDLE.
- All outputs are registered.
- Write-to-commit: second write at edge N → new_bd high and free_bd updated in cycle N+1.
- Committed descriptor visible to reader one cycle after commit (pend updated at the same edge as free_bd).
- Read latency:
  - re_s sampled high in IDLE at edge N with pend≠0 → first ack_o_s in cycle N+1.
  - Second ack in cycle N+3 if re_s is held high.
  - Minimum 2 cycles between acks; exactly 2 acks per descriptor.
- dat_out_s holds its last value outside ack cycles.
- a_cmp updates free_bd at the next edge.

## Test plan
- Reset: assert rst → free_bd=16, ack_o_s=0, new_bd=0. Release and hold re_s=1 with empty queue → no ack for 20 cycles.
- Single descriptor: write 0x0000_1000 then 0x0000_0200 → new_bd pulse one cycle later, free_bd=15. Hold re_s=1 → acks in cycles +1 and +3 carrying 0x1000 then 0x200, no third ack while re_s=1. Pulse a_cmp → free_bd=16.
- Full queue: write 16 descriptors → free_bd=0. 33rd word → bd_ovf pulse, free_bd stays 0. Read all 16 and a_cmp each → free_bd=16, data in order, pointers wrap correctly on a second fill of 16.
- Simultaneous commit + a_cmp with free_bd=10 → free_bd stays 10. Commit + WORD1 → pend unchanged.
- Spurious a_cmp with free_bd=16 → free_bd stays 16.
- Abort: write one word, assert bd_clr (or rst) during GAP → ack_o_s=0, free_bd=16. A new pair written afterwards reads back exactly, with no stale half-descriptor.
